// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the memory-mapped UART transmitter
//
// Contents:
//   tx_state_e  - transmit FSM states (IDLE/START/DATA/STOP)
//   OFF_*       - register offsets, taken from Addr[3:2]
//   ST_*        - bit positions inside the STATUS register
package uart_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_e;

    localparam logic [1:0] OFF_TXDATA = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_CTRL   = 2'd2;

    localparam int ST_FULL    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_BUSY    = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_CNT_LSB = 8;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with occupancy count
//
// Ports:
//   clk, reset     - clock and synchronous active-low reset (empties the FIFO)
//   push, din      - write request and data; ignored while full
//   pop, dout      - read request and head-of-queue data (combinational); ignored while empty
//   count          - number of stored entries, 0..DEPTH
//   full, empty    - count == DEPTH / count == 0
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];

    // Acceptance is judged on the pre-edge count, so a push into a full
    // FIFO is dropped even when a pop frees a slot on the same edge.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible once counted.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped 8N1 UART transmitter with TX FIFO
//
// Ports:
//   clk, reset  - core clock, synchronous active-low reset
//   MemWrite    - store strobe from the core
//   Addr        - data address (core ALUResult); Addr[3:2] select the register
//   WriteData   - store data
//   ReadData    - register read data, combinational, 0 outside the window
//   Hit         - Addr lies in the 16-byte window at BASE_ADDR
//   tx          - registered serial output, idles high
//
// Register map (word offsets): 0 TXDATA (W), 1 STATUS (R/W1C overflow),
// 2 CTRL (R/W, bit 0 tx_en, resets to 1), 3 reserved.
// BASE_ADDR[3:0] must be 0, CLKS_PER_BIT >= 2, FIFO_DEPTH a power of two >= 2.
module mmio_uart_tx
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'hFFFF_FF00,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Hit,
    output logic        tx
);

    localparam int CW  = $clog2(FIFO_DEPTH) + 1;
    localparam int BCW = $clog2(CLKS_PER_BIT);

    // Bus decode
    logic       wr_en;
    logic [1:0] offset;
    logic       push_req;

    assign Hit      = (Addr[31:4] == BASE_ADDR[31:4]);
    assign offset   = Addr[3:2];
    assign wr_en    = MemWrite & Hit;
    assign push_req = wr_en && (offset == OFF_TXDATA);

    logic unused_bits;
    assign unused_bits = ^{WriteData[31:8], Addr[1:0]};

    // FIFO
    logic          fifo_pop;
    logic [7:0]    fifo_dout;
    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_req),
        .pop   (fifo_pop),
        .din   (WriteData[7:0]),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Control / status registers
    logic ovf_q, ovf_d;
    logic tx_en_q, tx_en_d;

    always_comb begin
        ovf_d   = ovf_q;
        tx_en_d = tx_en_q;
        if (push_req && fifo_full) begin
            ovf_d = 1'b1;
        end else if (wr_en && (offset == OFF_STATUS) && WriteData[ST_OVF]) begin
            ovf_d = 1'b0;
        end
        if (wr_en && (offset == OFF_CTRL)) begin
            tx_en_d = WriteData[0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ovf_q   <= 1'b0;
            tx_en_q <= 1'b1;
        end else begin
            ovf_q   <= ovf_d;
            tx_en_q <= tx_en_d;
        end
    end

    // Transmit FSM
    tx_state_e      state_q, state_d;
    logic [BCW-1:0] bit_cnt_q, bit_cnt_d;
    logic [2:0]     bit_idx_q, bit_idx_d;
    logic [7:0]     shift_q, shift_d;
    logic           tx_q, tx_d;
    logic           can_start;
    logic           bit_last;

    assign can_start = tx_en_q & ~fifo_empty;
    assign bit_last  = (bit_cnt_q == BCW'(CLKS_PER_BIT - 1));

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        fifo_pop  = 1'b0;
        case (state_q)
            S_IDLE: begin
                bit_cnt_d = '0;
                bit_idx_d = '0;
                if (can_start) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_dout;
                    state_d  = S_START;
                end
            end
            S_START: begin
                if (bit_last) begin
                    bit_cnt_d = '0;
                    bit_idx_d = '0;
                    state_d   = S_DATA;
                end else begin
                    bit_cnt_d = bit_cnt_q + BCW'(1);
                end
            end
            S_DATA: begin
                if (bit_last) begin
                    bit_cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        shift_d   = {1'b0, shift_q[7:1]};
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + BCW'(1);
                end
            end
            S_STOP: begin
                if (bit_last) begin
                    bit_cnt_d = '0;
                    // Chain straight into the next start bit when data is
                    // waiting so back-to-back frames have no idle gap.
                    if (can_start) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_dout;
                        state_d  = S_START;
                    end else begin
                        state_d  = S_IDLE;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + BCW'(1);
                end
            end
            default: begin
                state_d   = S_IDLE;
                bit_cnt_d = '0;
                bit_idx_d = '0;
            end
        endcase

        // tx is derived from the next state so the registered line changes
        // on the same edge as the state, with no decode glitches.
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
        end
    end

    assign tx = tx_q;

    // Read mux
    always_comb begin
        ReadData = '0;
        if (Hit) begin
            case (offset)
                OFF_STATUS: begin
                    ReadData[ST_FULL]             = fifo_full;
                    ReadData[ST_EMPTY]            = fifo_empty;
                    ReadData[ST_BUSY]             = (state_q != S_IDLE);
                    ReadData[ST_OVF]              = ovf_q;
                    ReadData[ST_CNT_LSB +: 8]     = 8'(fifo_count);
                end
                OFF_CTRL: begin
                    ReadData[0] = tx_en_q;
                end
                default: ReadData = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - directed self-checking bench for mmio_uart_tx
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE = 32'hFFFF_FF00;
    localparam logic [31:0] A_TX = BASE + 32'h0;
    localparam logic [31:0] A_ST = BASE + 32'h4;
    localparam logic [31:0] A_CT = BASE + 32'h8;
    localparam logic [31:0] A_RS = BASE + 32'hC;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWrite;
    logic [31:0] Addr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        Hit;
    logic        tx;

    int n_cmp = 0;
    int n_err = 0;

    mmio_uart_tx #(
        .BASE_ADDR    (BASE),
        .CLKS_PER_BIT (4),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .Addr      (Addr),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .Hit       (Hit),
        .tx        (tx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; the write lands on the following posedge.
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        MemWrite  = 1'b1;
        Addr      = a;
        WriteData = d;
        @(negedge clk);
        MemWrite  = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        MemWrite = 1'b0;
        Addr     = a;
        #1;
        d = ReadData;
    endtask

    // Expected line level at cycle i (0..39) of a frame carrying b.
    function automatic logic frame_bit(input logic [7:0] b, input int i);
        int k;
        k = i / 4;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return b[k-1];
    endfunction

    // Caller sits one cycle before frame position start_i.
    task automatic tx_frame(input logic [7:0] b, input int start_i);
        logic [31:0] st;
        for (int i = start_i; i < 40; i++) begin
            @(negedge clk);
            rd(A_ST, st);
            chk($sformatf("frame%02h_tx[%0d]", b, i), {31'b0, tx}, {31'b0, frame_bit(b, i)});
            chk($sformatf("frame%02h_busy[%0d]", b, i), {31'b0, st[2]}, 32'd1);
        end
    endtask

    task automatic idle_for(input string tag, input int n);
        int lows;
        lows = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        chk(tag, lows, 32'd0);
    endtask

    logic [31:0] r;

    initial begin
        reset = 1'b0; MemWrite = 1'b0; Addr = '0; WriteData = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Reset state
        chk("rst_tx", {31'b0, tx}, 32'd1);
        rd(A_ST, r); chk("rst_status", r, 32'h0000_0002);
        chk("rst_hit", {31'b0, Hit}, 32'd1);
        rd(A_CT, r); chk("rst_ctrl", r, 32'h0000_0001);
        rd(32'h0000_0004, r);
        chk("miss_hit", {31'b0, Hit}, 32'd0);
        chk("miss_rdata", r, 32'd0);

        // Single byte 0xA5
        @(negedge clk);
        wr(A_TX, 32'h0000_00A5);
        tx_frame(8'hA5, 0);
        @(negedge clk);
        rd(A_ST, r); chk("a5_status_after", r, 32'h0000_0002);
        chk("a5_tx_after", {31'b0, tx}, 32'd1);

        // Back-to-back 0x01, 0x80
        wr(A_TX, 32'h0000_0001);
        wr(A_TX, 32'h0000_0080);
        chk("b2b_first_start", {31'b0, tx}, 32'd0);
        tx_frame(8'h01, 1);
        tx_frame(8'h80, 0);
        @(negedge clk);
        rd(A_ST, r); chk("b2b_status_after", r, 32'h0000_0002);

        // Overflow
        wr(A_CT, 32'h0);
        wr(A_TX, 32'h11);
        wr(A_TX, 32'h22);
        wr(A_TX, 32'h33);
        wr(A_TX, 32'h44);
        rd(A_ST, r); chk("ovf_full_no_ovf", r, 32'h0000_0401);
        wr(A_TX, 32'h55);
        rd(A_ST, r); chk("ovf_set", r, 32'h0000_0409);
        chk("ovf_tx_idle", {31'b0, tx}, 32'd1);
        wr(A_ST, 32'h0000_0008);
        rd(A_ST, r); chk("ovf_cleared", r, 32'h0000_0401);
        wr(A_CT, 32'h1);
        tx_frame(8'h11, 0);
        tx_frame(8'h22, 0);
        tx_frame(8'h33, 0);
        tx_frame(8'h44, 0);
        @(negedge clk);
        rd(A_ST, r); chk("ovf_drained", r, 32'h0000_0002);

        // Reset mid-frame (0xC3, frame position 13 is data bit 2 = 0)
        wr(A_TX, 32'h0000_00C3);
        repeat (13) @(negedge clk);
        chk("midrst_tx_before", {31'b0, tx}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("midrst_tx_after", {31'b0, tx}, 32'd1);
        rd(A_ST, r); chk("midrst_status", r, 32'h0000_0002);
        rd(A_CT, r); chk("midrst_ctrl", r, 32'h0000_0001);
        idle_for("midrst_no_frame", 60);

        // Decode
        rd(BASE + 32'h10, r);
        chk("dec_out_hit", {31'b0, Hit}, 32'd0);
        chk("dec_out_rdata", r, 32'd0);
        wr(BASE + 32'h10, 32'h77);
        rd(A_ST, r); chk("dec_out_nopush", r, 32'h0000_0002);
        rd(A_RS, r);
        chk("dec_rsv_hit", {31'b0, Hit}, 32'd1);
        chk("dec_rsv_rdata", r, 32'd0);
        wr(A_RS, 32'hFFFF_FFFF);
        rd(A_ST, r); chk("dec_rsv_nowrite", r, 32'h0000_0002);
        Addr = A_TX; WriteData = 32'h99; MemWrite = 1'b0;
        @(negedge clk);
        rd(A_ST, r); chk("dec_nomemwrite", r, 32'h0000_0002);
        rd(BASE + 32'h7, r); chk("dec_lowbits_ignored", r, 32'h0000_0002);
        rd(A_TX, r); chk("dec_txdata_reads0", r, 32'd0);
        wr(A_CT, 32'hFFFF_FFFE);
        rd(A_CT, r); chk("ctrl_clear", r, 32'h0000_0000);
        wr(A_CT, 32'hFFFF_FFFF);
        rd(A_CT, r); chk("ctrl_set_masked", r, 32'h0000_0001);
        idle_for("dec_no_frame", 10);

        // tx_en cleared mid-frame with two bytes queued
        wr(A_TX, 32'hAA);
        wr(A_TX, 32'h55);
        wr(A_TX, 32'h0F);
        wr(A_CT, 32'h0);
        tx_frame(8'hAA, 3);
        @(negedge clk);
        rd(A_ST, r); chk("txen_off_status", r, 32'h0000_0200);
        idle_for("txen_off_no_frame", 60);
        rd(A_ST, r); chk("txen_off_count_kept", r, 32'h0000_0200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
